// File: rtl/mf_pll_lock_supervisor_if.sv
// PLL-side and status signals of the lock supervisor.
// The master modport is the supervisor; the slave modport is the PLL/software side.
interface mf_pll_lock_supervisor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_locked;
    logic             force_relock;
    logic             pll_rst;
    logic             core_reset;
    logic             lock_stable;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] relock_count;
    logic [CNT_W-1:0] timeout_count;

    modport master (
        input  pll_locked,
        input  force_relock,
        output pll_rst,
        output core_reset,
        output lock_stable,
        output state_o,
        output relock_count,
        output timeout_count
    );

    modport slave (
        output pll_locked,
        output force_relock,
        input  pll_rst,
        input  core_reset,
        input  lock_stable,
        input  state_o,
        input  relock_count,
        input  timeout_count
    );
endinterface

// File: rtl/mf_pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a continuously held lock,
// then releases the core reset; retries on timeout, lock loss or software request.
module mf_pll_lock_supervisor #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                    refclk,
    input  logic                    rst,
    mf_pll_lock_supervisor_if.master bus
);
    localparam int unsigned MaxHs     = (RST_HOLD_CYCLES > STABLE_CYCLES) ?
                                        RST_HOLD_CYCLES : STABLE_CYCLES;
    localparam int unsigned MaxCycles = (MaxHs > LOCK_TIMEOUT) ? MaxHs : LOCK_TIMEOUT;
    localparam int unsigned CntBits   = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntBits-1:0] HoldLast    = CntBits'(RST_HOLD_CYCLES - 1);
    localparam logic [CntBits-1:0] StableLast  = CntBits'(STABLE_CYCLES - 1);
    localparam logic [CntBits-1:0] TimeoutLast = CntBits'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CountMax    = '1;

    typedef enum logic [1:0] {
        StResetPll = 2'd0,
        StWaitLock = 2'd1,
        StSettle   = 2'd2,
        StRun      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CntBits-1:0] cnt_q, cnt_d;
    logic [1:0]         sync_q;
    logic               lk;
    logic [CNT_W-1:0]   relock_q, relock_d;
    logic [CNT_W-1:0]   timeout_q, timeout_d;
    logic               pll_rst_q, core_reset_q, lock_stable_q;

    assign lk = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        relock_d  = relock_q;
        timeout_d = timeout_q;
        // A forced relock outranks every lock-driven transition, including a lock loss in RUN.
        if (bus.force_relock) begin
            state_d = StResetPll;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (cnt_q == HoldLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (lk) begin
                        state_d = StSettle;
                    end else if (cnt_q == TimeoutLast) begin
                        state_d = StResetPll;
                        if (timeout_q != CountMax) timeout_d = timeout_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (!lk) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!lk) begin
                        state_d = StResetPll;
                        if (relock_q != CountMax) relock_d = relock_q + 1'b1;
                    end
                end
                default: state_d = StResetPll;
            endcase
        end
        if (bus.force_relock || (state_d != state_q)) cnt_d = '0;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q        <= '0;
            state_q       <= StResetPll;
            cnt_q         <= '0;
            relock_q      <= '0;
            timeout_q     <= '0;
            pll_rst_q     <= 1'b1;
            core_reset_q  <= 1'b1;
            lock_stable_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], bus.pll_locked};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            relock_q      <= relock_d;
            timeout_q     <= timeout_d;
            // Decoded from the next state so outputs move on the same edge as state_o.
            pll_rst_q     <= (state_d == StResetPll);
            core_reset_q  <= (state_d != StRun);
            lock_stable_q <= (state_d == StRun);
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.core_reset    = core_reset_q;
    assign bus.lock_stable   = lock_stable_q;
    assign bus.state_o       = state_q;
    assign bus.relock_count  = relock_q;
    assign bus.timeout_count = timeout_q;
endmodule

// File: tb/tb_mf_pll_lock_supervisor.sv
// Directed and random bench for mf_pll_lock_supervisor with a dwell-time based
// reference model checked after every clock edge.
module tb_mf_pll_lock_supervisor;
    localparam int unsigned H = 4;
    localparam int unsigned S = 8;
    localparam int unsigned T = 32;
    localparam int unsigned W = 8;
    localparam int          SatMax = (1 << W) - 1;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    mf_pll_lock_supervisor_if #(.CNT_W(W)) bus ();

    mf_pll_lock_supervisor #(
        .RST_HOLD_CYCLES (H),
        .STABLE_CYCLES   (S),
        .LOCK_TIMEOUT    (T),
        .CNT_W           (W)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: state number, cycles spent in it, event tallies, and the pll_locked
    // samples still in flight through the two-stage synchronizer.
    int m_st    = 0;
    int m_dwell = 0;
    int m_tc    = 0;
    int m_rc    = 0;
    int m_old   = 0;
    int m_new   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_step();
        int  lk;
        int  nxt;
        if (rst) begin
            m_st = 0; m_dwell = 0; m_tc = 0; m_rc = 0; m_old = 0; m_new = 0;
        end else begin
            lk  = m_old;
            nxt = m_st;
            if (bus.force_relock) begin
                nxt = 0;
            end else if (m_st == 0) begin
                if (m_dwell == H - 1) nxt = 1;
            end else if (m_st == 1) begin
                if (lk != 0) nxt = 2;
                else if (m_dwell == T - 1) begin
                    nxt = 0;
                    if (m_tc < SatMax) m_tc++;
                end
            end else if (m_st == 2) begin
                if (lk == 0) nxt = 1;
                else if (m_dwell == S - 1) nxt = 3;
            end else if (lk == 0) begin
                nxt = 0;
                if (m_rc < SatMax) m_rc++;
            end
            if (bus.force_relock || nxt != m_st) m_dwell = 0;
            else m_dwell++;
            m_st  = nxt;
            m_old = m_new;
            m_new = bus.pll_locked ? 1 : 0;
        end
    endtask

    task automatic check_all();
        chk("state_o",       32'(bus.state_o),       32'(m_st));
        chk("pll_rst",       32'(bus.pll_rst),       32'(m_st == 0));
        chk("core_reset",    32'(bus.core_reset),    32'(m_st != 3));
        chk("lock_stable",   32'(bus.lock_stable),   32'(m_st == 3));
        chk("relock_count",  32'(bus.relock_count),  32'(m_rc));
        chk("timeout_count", 32'(bus.timeout_count), 32'(m_tc));
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_state(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (32'(bus.state_o) != target && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.state_o), 32'(target));
    endtask

    initial begin
        int n;
        bus.pll_locked   = 1'b0;
        bus.force_relock = 1'b0;

        // Reset, then the PLL reset hold window.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.pll_rst !== 1'b0 && n < 50);
        chk("rst_hold_len", 32'(n), 32'(H));
        chk("enter_wait_lock", 32'(bus.state_o), 32'd1);

        // Lock arrives 5 cycles into WAIT_LOCK; settle window to RUN.
        repeat (4) tick();
        bus.pll_locked = 1'b1;
        wait_state("reach_settle", 2, 20);
        n = 0;
        do begin tick(); n++; end while (bus.state_o !== 2'd3 && n < 50);
        chk("settle_len", 32'(n), 32'(S));
        chk("run_core_reset", 32'(bus.core_reset), 32'd0);
        chk("run_lock_stable", 32'(bus.lock_stable), 32'd1);

        // Lock loss in RUN, then recovery.
        bus.pll_locked = 1'b0;
        wait_state("lock_loss", 0, 20);
        chk("relock_one", 32'(bus.relock_count), 32'd1);
        bus.pll_locked = 1'b1;
        wait_state("recover_run", 3, 100);

        // Forced relock in RUN and SETTLE; restart of the hold count.
        bus.force_relock = 1'b1; tick(); bus.force_relock = 1'b0;
        chk("force_in_run", 32'(bus.state_o), 32'd0);
        chk("force_no_relock_inc", 32'(bus.relock_count), 32'd1);
        wait_state("reach_settle2", 2, 50);
        bus.force_relock = 1'b1; tick(); bus.force_relock = 1'b0;
        chk("force_in_settle", 32'(bus.state_o), 32'd0);
        bus.pll_locked = 1'b0;
        repeat (2) tick();
        bus.force_relock = 1'b1; tick(); bus.force_relock = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.pll_rst !== 1'b0 && n < 50);
        chk("force_restart_hold", 32'(n), 32'(H));

        // Lock timeout and counter saturation.
        n = 0;
        do begin tick(); n++; end while (bus.state_o !== 2'd0 && n < 100);
        chk("timeout_len", 32'(n), 32'(T));
        chk("timeout_one", 32'(bus.timeout_count), 32'd1);
        repeat (300 * (H + T)) tick();
        chk("timeout_saturated", 32'(bus.timeout_count), 32'(SatMax));

        // One-cycle lock glitch in SETTLE, then reset while in RUN.
        bus.pll_locked = 1'b1;
        wait_state("reach_settle3", 2, 100);
        repeat (3) tick();
        bus.pll_locked = 1'b0; tick(); bus.pll_locked = 1'b1;
        wait_state("glitch_to_wait", 1, 10);
        wait_state("glitch_resettle", 2, 10);
        n = 0;
        do begin tick(); n++; end while (bus.state_o !== 2'd3 && n < 50);
        chk("resettle_len", 32'(n), 32'(S));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_pll_rst", 32'(bus.pll_rst), 32'd1);
        chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
        chk("rst_lock_stable", 32'(bus.lock_stable), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_count), 32'd0);

        // Random lock behaviour, requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.pll_locked = ~bus.pll_locked;
            bus.force_relock = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        bus.force_relock = 1'b0;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
